// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the 5-stage core.
// Resolves trap, taken branch, multi-cycle MDU and load-use hazards,
// holds fetch on instruction-memory wait, and counts PC stall cycles.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap,
    input  logic        ex_branch_taken,
    input  logic        ex_mdu_start,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        imem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles
);

    localparam int unsigned STALL_W = 32;
    // Countdown preload: the start cycle and the release cycle are not counted.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               mdu_busy_q;
    logic               ldu;

    // Load-use: EX load writes a register the ID instruction reads (x0 excluded).
    assign ldu = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));

    // State and MDU countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and countdown update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (trap || ex_branch_taken) begin
                    state_d = RUN;
                end else if (ex_mdu_start) begin
                    state_d = MDU;
                    cnt_d   = CNT_LOAD;
                end
            end
            MDU: begin
                if (trap) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Mealy stall/flush decode; everything forced low during reset.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (trap) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (ex_mdu_start) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (ldu) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (!imem_ready) begin
                        pc_stall     = 1'b1;
                        if_id_flush  = 1'b1;
                    end
                end
                MDU: begin
                    if (trap) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (cnt_q != '0) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    // Registered busy flag, mirrors the MDU state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_busy_q <= 1'b0;
        end else begin
            mdu_busy_q <= (state_d == MDU);
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    assign mdu_busy     = mdu_busy_q;
    assign stall_cycles = stall_cnt_q;

endmodule
